// File: rtl/isp_awb_gain_if.sv
// Pixel stream bundle for the AWB gain stage: raw Bayer pixels in, gained
// pixels out, plus the end-of-frame marker travelling with the output.
interface isp_awb_gain_if #(
    parameter int BITS = 8
);
    logic            in_valid;
    logic [BITS-1:0] in_raw;
    logic            out_valid;
    logic [BITS-1:0] out_raw;
    logic            frame_done;

    // Pixel source side (drives raw pixels, consumes gained pixels)
    modport master (
        output in_valid, in_raw,
        input  out_valid, out_raw, frame_done
    );

    // Gain stage side
    modport slave (
        input  in_valid, in_raw,
        output out_valid, out_raw, frame_done
    );
endinterface

// File: rtl/isp_awb_gain.sv
// Bayer-domain white-balance gain stage with double-buffered per-channel
// gains and CFA pattern. New settings become active only at frame
// boundaries. Gain multiply is rounded and saturated, fixed latency 3.
// Optional: define AWB_STATS_EN to add per-frame pre-gain channel sums.
module isp_awb_gain #(
    parameter int BITS      = 8,
    parameter int WIDTH     = 1936,
    parameter int HEIGHT    = 1088,
    parameter int GAIN_BITS = 8,
    parameter int GAIN_FRAC = 4
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    isp_awb_gain_if.slave        pix,
    input  logic [1:0]           cfg_pat,
    input  logic [GAIN_BITS-1:0] cfg_gain_r,
    input  logic [GAIN_BITS-1:0] cfg_gain_gr,
    input  logic [GAIN_BITS-1:0] cfg_gain_gb,
    input  logic [GAIN_BITS-1:0] cfg_gain_b,
    input  logic                 cfg_wr,
    output logic                 cfg_pending
`ifdef AWB_STATS_EN
    ,
    output logic [BITS+21:0]     stat_sum_r,
    output logic [BITS+21:0]     stat_sum_g,
    output logic [BITS+21:0]     stat_sum_b,
    output logic                 stat_valid
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PW = BITS + GAIN_BITS;
    localparam logic [CW-1:0]        COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0]        ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [GAIN_BITS-1:0] UNITY    = GAIN_BITS'(1 << GAIN_FRAC);
    localparam logic [PW:0]          RND      = (PW + 1)'(1 << (GAIN_FRAC - 1));
    localparam logic [PW:0]          PIX_MAX  = (PW + 1)'((1 << BITS) - 1);

    // Gain arrays are indexed by channel: 0 R, 1 Gr, 2 Gb, 3 B
    logic [GAIN_BITS-1:0] cfg_gain [4];
    logic [GAIN_BITS-1:0] sh_gain_q [4], sh_gain_d [4];
    logic [GAIN_BITS-1:0] act_gain_q [4], act_gain_d [4];
    logic [1:0]           sh_pat_q, sh_pat_d, act_pat_q, act_pat_d;
    logic                 pending_q, pending_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;

    logic                 col_wrap, row_wrap, last_pix, load;
    logic [1:0]           idx;

    logic [BITS-1:0]      s1_raw_q, s1_raw_d;
    logic [GAIN_BITS-1:0] s1_gain_q, s1_gain_d;
    logic                 s1_v_q, s1_v_d, s1_last_q, s1_last_d;
    logic [PW-1:0]        s2_prod_q, s2_prod_d;
    logic                 s2_v_q, s2_v_d, s2_last_q, s2_last_d;
    logic [PW:0]          rnd_sum, rnd_shift;
    logic [BITS-1:0]      out_raw_q, out_raw_d;
    logic                 out_valid_q, out_valid_d, frame_done_q, frame_done_d;

    assign cfg_gain[0] = cfg_gain_r;
    assign cfg_gain[1] = cfg_gain_gr;
    assign cfg_gain[2] = cfg_gain_gb;
    assign cfg_gain[3] = cfg_gain_b;

    assign col_wrap = (col_q == COL_LAST);
    assign row_wrap = (row_q == ROW_LAST);
    assign last_pix = pix.in_valid && col_wrap && row_wrap;
    // Second load case covers settings written while idle before the first pixel
    assign load     = last_pix ||
                      (pending_q && (col_q == '0) && (row_q == '0) && !pix.in_valid);
    assign idx      = {row_q[0], col_q[0]} ^ act_pat_q;

    // Raster position; frozen whenever no pixel is accepted
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix.in_valid) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Shadow capture and frame-boundary promotion; a load always takes the old shadow
    always_comb begin
        sh_gain_d  = sh_gain_q;
        act_gain_d = act_gain_q;
        sh_pat_d   = sh_pat_q;
        act_pat_d  = act_pat_q;
        pending_d  = pending_q;
        if (load) begin
            act_gain_d = sh_gain_q;
            act_pat_d  = sh_pat_q;
            pending_d  = 1'b0;
        end
        if (cfg_wr) begin
            sh_gain_d = cfg_gain;
            sh_pat_d  = cfg_pat;
            pending_d = 1'b1;
        end
    end

    // Three-stage datapath: capture, multiply, round and saturate
    always_comb begin
        s1_raw_d     = pix.in_raw;
        s1_gain_d    = act_gain_q[idx];
        s1_v_d       = pix.in_valid;
        s1_last_d    = last_pix;
        s2_prod_d    = PW'(s1_raw_q) * PW'(s1_gain_q);
        s2_v_d       = s1_v_q;
        s2_last_d    = s1_last_q;
        rnd_sum      = {1'b0, s2_prod_q} + RND;
        rnd_shift    = rnd_sum >> GAIN_FRAC;
        out_raw_d    = out_raw_q;
        if (s2_v_q) begin
            out_raw_d = (rnd_shift > PIX_MAX) ? '1 : rnd_shift[BITS-1:0];
        end
        out_valid_d  = s2_v_q;
        frame_done_d = s2_last_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                sh_gain_q[i]  <= UNITY;
                act_gain_q[i] <= UNITY;
            end
            sh_pat_q     <= '0;
            act_pat_q    <= '0;
            pending_q    <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            s1_raw_q     <= '0;
            s1_gain_q    <= '0;
            s1_v_q       <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_prod_q    <= '0;
            s2_v_q       <= 1'b0;
            s2_last_q    <= 1'b0;
            out_raw_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sh_gain_q    <= sh_gain_d;
            act_gain_q   <= act_gain_d;
            sh_pat_q     <= sh_pat_d;
            act_pat_q    <= act_pat_d;
            pending_q    <= pending_d;
            col_q        <= col_d;
            row_q        <= row_d;
            s1_raw_q     <= s1_raw_d;
            s1_gain_q    <= s1_gain_d;
            s1_v_q       <= s1_v_d;
            s1_last_q    <= s1_last_d;
            s2_prod_q    <= s2_prod_d;
            s2_v_q       <= s2_v_d;
            s2_last_q    <= s2_last_d;
            out_raw_q    <= out_raw_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cfg_pending    = pending_q;
    assign pix.out_raw    = out_raw_q;
    assign pix.out_valid  = out_valid_q;
    assign pix.frame_done = frame_done_q;

`ifdef AWB_STATS_EN
    localparam int SW = BITS + 22;
    logic [SW-1:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
    logic [SW-1:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    logic [SW-1:0] add_r, add_g, add_b, new_r, new_g, new_b;
    logic          stat_valid_q, stat_valid_d;

    // Pre-gain per-channel accumulation; last pixel included in the published sums
    always_comb begin
        add_r = '0;
        add_g = '0;
        add_b = '0;
        if (pix.in_valid) begin
            case (idx)
                2'b00:   add_r = SW'(pix.in_raw);
                2'b11:   add_b = SW'(pix.in_raw);
                default: add_g = SW'(pix.in_raw);
            endcase
        end
        new_r        = acc_r_q + add_r;
        new_g        = acc_g_q + add_g;
        new_b        = acc_b_q + add_b;
        acc_r_d      = new_r;
        acc_g_d      = new_g;
        acc_b_d      = new_b;
        sum_r_d      = sum_r_q;
        sum_g_d      = sum_g_q;
        sum_b_d      = sum_b_q;
        stat_valid_d = 1'b0;
        if (last_pix) begin
            acc_r_d      = '0;
            acc_g_d      = '0;
            acc_b_d      = '0;
            sum_r_d      = new_r;
            sum_g_d      = new_g;
            sum_b_d      = new_b;
            stat_valid_d = 1'b1;
        end
    end

    // Statistics registers
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            acc_r_q      <= '0;
            acc_g_q      <= '0;
            acc_b_q      <= '0;
            sum_r_q      <= '0;
            sum_g_q      <= '0;
            sum_b_q      <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            acc_r_q      <= acc_r_d;
            acc_g_q      <= acc_g_d;
            acc_b_q      <= acc_b_d;
            sum_r_q      <= sum_r_d;
            sum_g_q      <= sum_g_d;
            sum_b_q      <= sum_b_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    assign stat_sum_r = sum_r_q;
    assign stat_sum_g = sum_g_q;
    assign stat_sum_b = sum_b_q;
    assign stat_valid = stat_valid_q;
`endif
endmodule

// File: tb/tb_isp_awb_gain.sv
// Self-checking bench for isp_awb_gain on a 4x2 frame. Expected pixels are
// pushed to a scoreboard when driven and popped when the DUT emits them.
module tb_isp_awb_gain;
    localparam int BITS = 8;
    localparam int W    = 4;
    localparam int H    = 2;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cfg_pat;
    logic [7:0] cfg_gain_r, cfg_gain_gr, cfg_gain_gb, cfg_gain_b;
    logic       cfg_wr;
    logic       cfg_pending;
`ifdef AWB_STATS_EN
    logic [BITS+21:0] stat_sum_r, stat_sum_g, stat_sum_b;
    logic             stat_valid;
`endif

    isp_awb_gain_if #(.BITS(BITS)) pix ();

    isp_awb_gain #(
        .BITS(BITS), .WIDTH(W), .HEIGHT(H), .GAIN_BITS(8), .GAIN_FRAC(4)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .pix(pix),
        .cfg_pat(cfg_pat), .cfg_gain_r(cfg_gain_r), .cfg_gain_gr(cfg_gain_gr),
        .cfg_gain_gb(cfg_gain_gb), .cfg_gain_b(cfg_gain_b),
        .cfg_wr(cfg_wr), .cfg_pending(cfg_pending)
`ifdef AWB_STATS_EN
        , .stat_sum_r(stat_sum_r), .stat_sum_g(stat_sum_g),
        .stat_sum_b(stat_sum_b), .stat_valid(stat_valid)
`endif
    );

    always #5 pclk = ~pclk;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [7:0]  raw;
        logic        last;
        logic [31:0] cyc;
    } exp_t;
    exp_t sb_q[$];

    // Bench model of the active/shadow gain sets (0 R, 1 Gr, 2 Gb, 3 B)
    logic [7:0] m_gain [4];
    logic [1:0] m_pat;
    logic [7:0] s_gain [4];
    logic [1:0] s_pat;
    logic       m_pending;
    logic [7:0] hold_raw = 8'h00;

`ifdef AWB_STATS_EN
    typedef struct packed { logic [31:0] r; logic [31:0] g; logic [31:0] b; } st_t;
    st_t st_q[$];
`endif

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_px(input logic [7:0] raw, input logic [7:0] g);
        int p;
        p = (int'(raw) * int'(g) + 8) / 16;
        return (p > 255) ? 8'hFF : 8'(p);
    endfunction

    // Output monitor: scoreboard compare, latency, hold and idle checks
    always @(negedge pclk) begin
        exp_t e;
        if (!rst_n) begin
            hold_raw = 8'h00;
        end else if (pix.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_raw", {24'd0, pix.out_raw}, {24'd0, e.raw});
                check("frame_done", {31'd0, pix.frame_done}, {31'd0, e.last});
                check("latency", cyc, e.cyc);
                hold_raw = e.raw;
                $display("[TB] out raw=%02h exp=%02h last=%0d cyc=%0d",
                         pix.out_raw, e.raw, pix.frame_done, cyc);
            end
        end else begin
            check("hold_raw", {24'd0, pix.out_raw}, {24'd0, hold_raw});
            check("idle_frame_done", {31'd0, pix.frame_done}, 32'd0);
        end
    end

`ifdef AWB_STATS_EN
    // Statistics monitor: one pulse per completed frame
    always @(negedge pclk) begin
        st_t s;
        if (rst_n && stat_valid === 1'b1) begin
            if (st_q.size() == 0) begin
                check("unexpected_stat_valid", 32'd1, 32'd0);
            end else begin
                s = st_q.pop_front();
                check("stat_sum_r", 32'(stat_sum_r), s.r);
                check("stat_sum_g", 32'(stat_sum_g), s.g);
                check("stat_sum_b", 32'(stat_sum_b), s.b);
                $display("[TB] stats r=%0d g=%0d b=%0d", stat_sum_r, stat_sum_g, stat_sum_b);
            end
        end
    end
`endif

    // One cycle of input; expected output queued for pixels
    task automatic send(input logic v, input logic [7:0] raw, input logic last, input logic [7:0] g);
        exp_t e;
        pix.in_valid = v;
        pix.in_raw   = raw;
        if (v) begin
            e.raw  = model_px(raw, g);
            e.last = last;
            e.cyc  = cyc + 3;
            sb_q.push_back(e);
        end
        @(posedge pclk);
        #1;
        pix.in_valid = 1'b0;
    endtask

    task automatic cfg_set(input logic [1:0] pat, input logic [7:0] r, input logic [7:0] gr,
                           input logic [7:0] gb, input logic [7:0] b);
        cfg_pat     = pat;
        cfg_gain_r  = r;
        cfg_gain_gr = gr;
        cfg_gain_gb = gb;
        cfg_gain_b  = b;
    endtask

    task automatic strobe();
        cfg_wr    = 1'b1;
        s_gain    = '{cfg_gain_r, cfg_gain_gr, cfg_gain_gb, cfg_gain_b};
        s_pat     = cfg_pat;
        m_pending = 1'b1;
    endtask

    // Write settings while idle at the frame start; promoted one cycle later
    task automatic commit_idle();
        strobe();
        send(1'b0, 8'h00, 1'b0, 8'h00);
        cfg_wr = 1'b0;
        check("pending_set", {31'd0, cfg_pending}, 32'd1);
        send(1'b0, 8'h00, 1'b0, 8'h00);
        m_gain    = s_gain;
        m_pat     = s_pat;
        m_pending = 1'b0;
        check("pending_idle_load", {31'd0, cfg_pending}, 32'd0);
    endtask

    task automatic frame(input logic [7:0] raw_c, input bit rnd_raw, input bit gaps, input int wr_at);
        int         n;
        int         sr, sg, sb;
        logic [1:0] idx;
        logic [7:0] raw;
        logic       last;
        n = 0; sr = 0; sg = 0; sb = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps)
                    for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++)
                        send(1'b0, 8'($urandom_range(0, 255)), 1'b0, 8'h00);
                raw  = rnd_raw ? 8'($urandom_range(0, 255)) : raw_c;
                idx  = {r[0], c[0]} ^ m_pat;
                last = (r == H - 1) && (c == W - 1);
                case (idx)
                    2'b00:   sr += int'(raw);
                    2'b11:   sb += int'(raw);
                    default: sg += int'(raw);
                endcase
                if (n == wr_at) strobe();
                if (last && m_pending)
                    check("pending_at_last", {31'd0, cfg_pending}, 32'd1);
                send(1'b1, raw, last, m_gain[idx]);
                cfg_wr = 1'b0;
                if (last) begin
`ifdef AWB_STATS_EN
                    st_q.push_back('{r: sr, g: sg, b: sb});
`endif
                    if (m_pending) begin
                        m_gain    = s_gain;
                        m_pat     = s_pat;
                        m_pending = 1'b0;
                    end
                    check("pending_after_frame", {31'd0, cfg_pending}, {31'd0, m_pending});
                end else if (m_pending) begin
                    check("pending_mid", {31'd0, cfg_pending}, 32'd1);
                end
                n++;
            end
        end
    endtask

    task automatic model_reset();
        m_gain    = '{8'h10, 8'h10, 8'h10, 8'h10};
        s_gain    = m_gain;
        m_pat     = 2'b00;
        s_pat     = 2'b00;
        m_pending = 1'b0;
    endtask

    initial begin
        pix.in_valid = 1'b0;
        pix.in_raw   = 8'h00;
        cfg_wr       = 1'b0;
        cfg_set(2'b00, 8'h10, 8'h10, 8'h10, 8'h10);
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_out_valid", {31'd0, pix.out_valid}, 32'd0);
        check("rst_out_raw", {24'd0, pix.out_raw}, 32'd0);
        check("rst_frame_done", {31'd0, pix.frame_done}, 32'd0);
        check("rst_cfg_pending", {31'd0, cfg_pending}, 32'd0);
`ifdef AWB_STATS_EN
        check("rst_stat_valid", {31'd0, stat_valid}, 32'd0);
        check("rst_stat_sum_g", 32'(stat_sum_g), 32'd0);
`endif

        // Unity gains after reset
        frame(8'd100, 1'b0, 1'b0, -1);

        // Per-channel gains, pattern RGGB then BGGR
        cfg_set(2'b00, 8'h1E, 8'h10, 8'h10, 8'h1C);
        commit_idle();
        frame(8'h40, 1'b0, 1'b0, -1);
        cfg_set(2'b11, 8'h1E, 8'h10, 8'h10, 8'h1C);
        commit_idle();
        frame(8'h40, 1'b0, 1'b0, -1);

        // Saturation, rounding, zero gain
        cfg_set(2'b00, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        commit_idle();
        frame(8'hFF, 1'b0, 1'b0, -1);
        cfg_set(2'b00, 8'h18, 8'h18, 8'h18, 8'h18);
        commit_idle();
        frame(8'h03, 1'b0, 1'b0, -1);
        cfg_set(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        commit_idle();
        frame(8'h00, 1'b1, 1'b0, -1);

        // Mid-frame write: old gains to end of frame, new from next frame
        cfg_set(2'b00, 8'h10, 8'h10, 8'h10, 8'h10);
        commit_idle();
        cfg_set(2'b00, 8'h20, 8'h10, 8'h10, 8'h10);
        frame(8'h40, 1'b0, 1'b0, 3);
        frame(8'h40, 1'b0, 1'b0, -1);

        // Random data with and without input gaps
        cfg_set(2'b01, 8'h1A, 8'h13, 8'h0E, 8'h25);
        commit_idle();
        frame(8'h00, 1'b1, 1'b0, -1);
        frame(8'h00, 1'b1, 1'b1, -1);
        frame(8'h00, 1'b1, 1'b1, -1);

        // Reset mid-frame with a pending write
        cfg_set(2'b10, 8'h30, 8'h30, 8'h30, 8'h30);
        send(1'b1, 8'h11, 1'b0, m_gain[2'b00 ^ m_pat]);
        strobe();
        send(1'b1, 8'h22, 1'b0, m_gain[2'b01 ^ m_pat]);
        cfg_wr = 1'b0;
        send(1'b1, 8'h33, 1'b0, m_gain[2'b00 ^ m_pat]);
        rst_n = 1'b0;
        @(posedge pclk);
        #1;
        check("midrst_out_valid", {31'd0, pix.out_valid}, 32'd0);
        check("midrst_cfg_pending", {31'd0, cfg_pending}, 32'd0);
        check("midrst_out_raw", {24'd0, pix.out_raw}, 32'd0);
        sb_q.delete();
        model_reset();
        rst_n = 1'b1;
        frame(8'h00, 1'b1, 1'b0, -1);

        // Statistics frame: all pixels 10 at unity gain
        frame(8'd10, 1'b0, 1'b0, -1);

        // Drain the pipeline with a bounded wait
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge pclk);
        repeat (2) @(posedge pclk);
        check("drain_scoreboard", sb_q.size(), 32'd0);
`ifdef AWB_STATS_EN
        check("drain_stats", st_q.size(), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
